// File: rtl/jk_btn_conditioner.sv
// Button front end for the ON/OFF JK FSM. Each raw button is synchronised and debounced.
// A debounced press becomes a one-cycle j or k pulse; a press on both buttons in the same cycle gives a conflict pulse.
module jk_btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_on_raw,
   input  logic btn_off_raw,
   output logic j,
   output logic k,
   output logic conflict,
   output logic on_level,
   output logic off_level
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Channel 0 is ON, channel 1 is OFF.
   logic [1:0] raw_vec;
   logic [1:0] rise_vec;
   logic [1:0] level_vec;

   assign raw_vec = {btn_off_raw, btn_on_raw};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} deb_state_t;

         logic [1:0]       sync_reg;
         deb_state_t       state_reg, state_next;
         logic [CNT_W-1:0] cnt_reg, cnt_next;
         logic             rise_next;
         logic             s_bit;

         assign s_bit = sync_reg[1];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync_reg  <= 2'b00;
               state_reg <= RELEASED;
               cnt_reg   <= '0;
            end else begin
               sync_reg  <= {sync_reg[0], raw_vec[gi]};
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
            end
         end

         // A mismatch run must last DEBOUNCE_CYCLES edges before the stable level follows s.
         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            rise_next  = 1'b0;
            if (s_bit == (state_reg == PRESSED)) begin
               cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
               cnt_next   = '0;
               state_next = s_bit ? PRESSED : RELEASED;
               rise_next  = s_bit;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         assign rise_vec[gi]  = rise_next;
         assign level_vec[gi] = (state_reg == PRESSED);
      end
   endgenerate

   logic j_reg, k_reg, conflict_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         j_reg        <= 1'b0;
         k_reg        <= 1'b0;
         conflict_reg <= 1'b0;
      end else begin
         j_reg        <= rise_vec[0] & ~rise_vec[1];
         k_reg        <= rise_vec[1] & ~rise_vec[0];
         conflict_reg <= rise_vec[0] &  rise_vec[1];
      end
   end

   assign j         = j_reg;
   assign k         = k_reg;
   assign conflict  = conflict_reg;
   assign on_level  = level_vec[0];
   assign off_level = level_vec[1];

endmodule
